wb_port_arbiter: RTL and testbench

- Shares the register file's single write-back port (write_back_en / dest_wb / result_wb) between two producers: requester A (EXE/ALU result) and requester B (MEM load result).
- Each requester has its own small FIFO. A round-robin arbiter pops one FIFO head per cycle and drives the register-file write port from registered outputs.
- Exports a pending-write bitmap, so hazard logic can stall reads of registers that still have queued writes.

---
 rtl/wb_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: two per-requester FIFOs feed one register-file write port through a
// round-robin grant and a registered output stage; also reports registers with queued writes.
module wb_port_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_dest,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_dest,
  input  logic [DATA_W-1:0] b_data,
  output logic              write_back_en,
  output logic [ADDR_W-1:0] dest_wb,
  output logic [DATA_W-1:0] result_wb,
  output logic [14:0]       pending,
  output logic              drop_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [ADDR_W-1:0] NoReg = ADDR_W'(15);

  // Index 0 is requester A, index 1 is requester B.
  logic [ADDR_W-1:0] mem_dest_q [2][DEPTH];
  logic [ADDR_W-1:0] mem_dest_d [2][DEPTH];
  logic [DATA_W-1:0] mem_data_q [2][DEPTH];
  logic [DATA_W-1:0] mem_data_d [2][DEPTH];
  logic [PtrW-1:0]   wr_ptr_q [2];
  logic [PtrW-1:0]   wr_ptr_d [2];
  logic [PtrW-1:0]   rd_ptr_q [2];
  logic [PtrW-1:0]   rd_ptr_d [2];
  logic [CntW-1:0]   cnt_q [2];
  logic [CntW-1:0]   cnt_d [2];

  logic              rr_q, rr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] dest_wb_q, dest_wb_d;
  logic [DATA_W-1:0] result_wb_q, result_wb_d;
  logic              drop_q, drop_d;

  logic [1:0]        in_valid;
  logic [ADDR_W-1:0] in_dest [2];
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        nonempty, ready, push, pop;
  logic              grant;
  logic [ADDR_W-1:0] head_dest;
  logic [DATA_W-1:0] head_data;

  always_comb begin
    in_valid   = {b_valid, a_valid};
    in_dest[0] = a_dest;
    in_dest[1] = b_dest;
    in_data[0] = a_data;
    in_data[1] = b_data;
  end

  // Ready depends only on registered occupancy, never on this cycle's grant.
  always_comb begin
    nonempty = '0;
    ready    = '0;
    push     = '0;
    for (int q = 0; q < 2; q++) begin
      nonempty[q] = cnt_q[q] != '0;
      ready[q]    = !rst && (cnt_q[q] != CntW'(DEPTH));
      push[q]     = in_valid[q] && ready[q];
    end
    pop[0]    = nonempty[0] && (!nonempty[1] || !rr_q);
    pop[1]    = nonempty[1] && !pop[0];
    grant     = |pop;
    head_dest = pop[1] ? mem_dest_q[1][rd_ptr_q[1]] : mem_dest_q[0][rd_ptr_q[0]];
    head_data = pop[1] ? mem_data_q[1][rd_ptr_q[1]] : mem_data_q[0][rd_ptr_q[0]];
  end

  always_comb begin
    mem_dest_d  = mem_dest_q;
    mem_data_d  = mem_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    for (int q = 0; q < 2; q++) begin
      if (push[q]) begin
        mem_dest_d[q][wr_ptr_q[q]] = in_dest[q];
        mem_data_d[q][wr_ptr_q[q]] = in_data[q];
        wr_ptr_d[q]                = wr_ptr_q[q] + PtrW'(1);
      end
      if (pop[q]) begin
        rd_ptr_d[q] = rd_ptr_q[q] + PtrW'(1);
      end
      case ({push[q], pop[q]})
        2'b10:   cnt_d[q] = cnt_q[q] + CntW'(1);
        2'b01:   cnt_d[q] = cnt_q[q] - CntW'(1);
        default: cnt_d[q] = cnt_q[q];
      endcase
    end

    // After a grant, prefer the requester that lost.
    rr_d        = grant ? pop[0] : rr_q;
    we_d        = 1'b0;
    drop_d      = 1'b0;
    dest_wb_d   = dest_wb_q;
    result_wb_d = result_wb_q;
    if (grant) begin
      if (head_dest == NoReg) begin
        drop_d = 1'b1;
      end else begin
        we_d        = 1'b1;
        dest_wb_d   = head_dest;
        result_wb_d = head_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int q = 0; q < 2; q++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_dest_q[q][i] <= '0;
          mem_data_q[q][i] <= '0;
        end
        wr_ptr_q[q] <= '0;
        rd_ptr_q[q] <= '0;
        cnt_q[q]    <= '0;
      end
      rr_q        <= 1'b0;
      we_q        <= 1'b0;
      dest_wb_q   <= '0;
      result_wb_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      mem_dest_q  <= mem_dest_d;
      mem_data_q  <= mem_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      we_q        <= we_d;
      dest_wb_q   <= dest_wb_d;
      result_wb_q <= result_wb_d;
      drop_q      <= drop_d;
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [PtrW-1:0] off;
    logic            vld;
    off     = '0;
    vld     = 1'b0;
    pending = '0;
    for (int q = 0; q < 2; q++) begin
      for (int i = 0; i < DEPTH; i++) begin
        off = PtrW'(i) - rd_ptr_q[q];
        vld = {1'b0, off} < cnt_q[q];
        for (int r = 0; r < 15; r++) begin
          if (vld && mem_dest_q[q][i] == ADDR_W'(r)) pending[r] = 1'b1;
        end
      end
    end
    for (int r = 0; r < 15; r++) begin
      if (we_q && dest_wb_q == ADDR_W'(r)) pending[r] = 1'b1;
    end
  end

  assign a_ready       = ready[0];
  assign b_ready       = ready[1];
  assign write_back_en = we_q;
  assign dest_wb       = dest_wb_q;
  assign result_wb     = result_wb_q;
  assign drop_err      = drop_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, single write, dest-15 drop, same-dest collision,
// round-robin contention and backpressure, with a negedge-sampled register-file model.
module tb_wb_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [AW-1:0] a_dest, b_dest, dest_wb;
  logic [DW-1:0] a_data, b_data, result_wb;
  logic          write_back_en, drop_err;
  logic [14:0]   pending;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_dest(a_dest), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
    .write_back_en(write_back_en), .dest_wb(dest_wb), .result_wb(result_wb),
    .pending(pending), .drop_err(drop_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int drops  = 0;
  logic [AW-1:0] log_dest[$];
  logic [DW-1:0] log_data[$];
  int            log_cyc[$];
  logic [DW-1:0] rf[16];

  always @(posedge clk) cyc <= cyc + 1;

  // Register file samples mid-cycle.
  always @(negedge clk) begin
    if (write_back_en) begin
      rf[dest_wb] <= result_wb;
      log_dest.push_back(dest_wb);
      log_data.push_back(result_wb);
      log_cyc.push_back(cyc);
    end
    if (drop_err) drops <= drops + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_dest.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic run_stream(input int na, input int nb, input logic [AW-1:0] da,
                            input logic [AW-1:0] db, input logic [DW-1:0] base_a,
                            input logic [DW-1:0] base_b, output bit b_low, output bit timeout);
    int ia = 0;
    int ib = 0;
    int n  = 0;
    bit fa, fb;
    b_low = 0;
    while ((ia < na || ib < nb) && n < 200) begin
      a_valid = (ia < na);
      a_dest  = da;
      a_data  = base_a + DW'(ia);
      b_valid = (ib < nb);
      b_dest  = db;
      b_data  = base_b + DW'(ib);
      fa = a_valid && a_ready;
      fb = b_valid && b_ready;
      if (b_valid && !b_ready) b_low = 1;
      tick();
      if (fa) ia++;
      if (fb) ib++;
      n++;
    end
    a_valid = 0;
    b_valid = 0;
    timeout = (n >= 200);
  endtask

  task automatic drain(output bit timeout);
    int n = 0;
    while ((write_back_en || pending != '0) && n < 50) begin
      tick();
      n++;
    end
    timeout = (n >= 50);
  endtask

  task automatic test_reset();
    rst = 1; a_valid = 0; b_valid = 0; a_dest = 0; b_dest = 0; a_data = 0; b_data = 0;
    tick();
    tick();
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready: got %b want 0", a_ready); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL rst_b_ready: got %b want 0", b_ready); end
    checks++; if (write_back_en !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", write_back_en); end
    checks++; if (dest_wb !== 4'd0) begin errors++; $display("FAIL rst_dest: got %h want 0", dest_wb); end
    checks++; if (result_wb !== 32'd0) begin errors++; $display("FAIL rst_result: got %h want 0", result_wb); end
    checks++; if (pending !== 15'd0) begin errors++; $display("FAIL rst_pending: got %h want 0", pending); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL rst_drop: got %b want 0", drop_err); end
    rst = 0;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b11) begin errors++; $display("FAIL rel_ready: got %b want 11", {a_ready, b_ready}); end
    clear_log();
    a_valid = 1; a_dest = 4'd7; a_data = 32'hAAAA0001;
    tick();
    a_data = 32'hAAAA0002;
    tick();
    a_valid = 0;
    checks++; if (pending !== 15'h0080) begin errors++; $display("FAIL pre_rst_pending: got %h want 0080", pending); end
    #2;
    rst = 1;
    #1;
    checks++; if (write_back_en !== 1'b0) begin errors++; $display("FAIL mid_rst_we: got %b want 0", write_back_en); end
    checks++; if (pending !== 15'd0) begin errors++; $display("FAIL mid_rst_pending: got %h want 0", pending); end
    checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL mid_rst_ready: got %b want 00", {a_ready, b_ready}); end
    tick();
    rst = 0;
    repeat (4) tick();
    checks++; if (log_dest.size() != 0) begin errors++; $display("FAIL rst_no_write: got %0d writes want 0", log_dest.size()); end
    checks++; if (pending !== 15'd0) begin errors++; $display("FAIL post_rst_pending: got %h want 0", pending); end
  endtask

  task automatic test_single();
    a_valid = 1; a_dest = 4'd3; a_data = 32'hDEADBEEF;
    tick();
    a_valid = 0;
    checks++; if (write_back_en !== 1'b0) begin errors++; $display("FAIL single_we_n: got %b want 0", write_back_en); end
    checks++; if (pending !== 15'h0008) begin errors++; $display("FAIL single_pend_n: got %h want 0008", pending); end
    tick();
    checks++; if (write_back_en !== 1'b1) begin errors++; $display("FAIL single_we: got %b want 1", write_back_en); end
    checks++; if (dest_wb !== 4'd3) begin errors++; $display("FAIL single_dest: got %h want 3", dest_wb); end
    checks++; if (result_wb !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", result_wb); end
    checks++; if (pending !== 15'h0008) begin errors++; $display("FAIL single_pend_wb: got %h want 0008", pending); end
    tick();
    checks++; if (write_back_en !== 1'b0) begin errors++; $display("FAIL single_we_off: got %b want 0", write_back_en); end
    checks++; if (pending !== 15'd0) begin errors++; $display("FAIL single_pend_off: got %h want 0", pending); end
    checks++; if (dest_wb !== 4'd3) begin errors++; $display("FAIL single_dest_hold: got %h want 3", dest_wb); end
    checks++; if (rf[3] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rf: got %h want deadbeef", rf[3]); end
  endtask

  task automatic test_dest15();
    int d0;
    d0 = drops;
    a_valid = 1; a_dest = 4'd15; a_data = 32'h1234;
    tick();
    a_valid = 0;
    checks++; if (pending !== 15'd0) begin errors++; $display("FAIL d15_pend: got %h want 0", pending); end
    b_valid = 1; b_dest = 4'd9; b_data = 32'h5555;
    tick();
    b_valid = 0;
    checks++; if (write_back_en !== 1'b0) begin errors++; $display("FAIL d15_we: got %b want 0", write_back_en); end
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL d15_drop: got %b want 1", drop_err); end
    checks++; if (dest_wb !== 4'd3) begin errors++; $display("FAIL d15_dest_hold: got %h want 3", dest_wb); end
    checks++; if (result_wb !== 32'hDEADBEEF) begin errors++; $display("FAIL d15_data_hold: got %h want deadbeef", result_wb); end
    checks++; if (pending !== 15'h0200) begin errors++; $display("FAIL d15_pend_b: got %h want 0200", pending); end
    tick();
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL d15_drop_off: got %b want 0", drop_err); end
    checks++; if ({write_back_en, dest_wb} !== 5'b1_1001) begin errors++; $display("FAIL d15_next_b: got %b want 11001", {write_back_en, dest_wb}); end
    checks++; if (result_wb !== 32'h5555) begin errors++; $display("FAIL d15_next_data: got %h want 5555", result_wb); end
    tick();
    checks++; if (drops - d0 != 1) begin errors++; $display("FAIL d15_drop_count: got %0d want 1", drops - d0); end
  endtask

  task automatic test_collision();
    a_valid = 1; a_dest = 4'd5; a_data = 32'd1;
    b_valid = 1; b_dest = 4'd5; b_data = 32'd2;
    tick();
    a_valid = 0; b_valid = 0;
    checks++; if (pending !== 15'h0020) begin errors++; $display("FAIL coll_pend_q: got %h want 0020", pending); end
    tick();
    checks++; if ({write_back_en, dest_wb, result_wb} !== {1'b1, 4'd5, 32'd1}) begin errors++; $display("FAIL coll_first: got we=%b d=%h r=%h want 1 5 1", write_back_en, dest_wb, result_wb); end
    checks++; if (pending !== 15'h0020) begin errors++; $display("FAIL coll_pend_mid: got %h want 0020", pending); end
    tick();
    checks++; if ({write_back_en, dest_wb, result_wb} !== {1'b1, 4'd5, 32'd2}) begin errors++; $display("FAIL coll_second: got we=%b d=%h r=%h want 1 5 2", write_back_en, dest_wb, result_wb); end
    tick();
    checks++; if (pending !== 15'd0) begin errors++; $display("FAIL coll_pend_end: got %h want 0", pending); end
    checks++; if (rf[5] !== 32'd2) begin errors++; $display("FAIL coll_rf5: got %h want 2", rf[5]); end
  endtask

  task automatic test_contention();
    bit bl, to;
    clear_log();
    run_stream(6, 6, 4'd1, 4'd2, 32'h100, 32'h200, bl, to);
    checks++; if (to) begin errors++; $display("FAIL cont_stream_timeout: got timeout want done"); end
    drain(to);
    checks++; if (to) begin errors++; $display("FAIL cont_drain_timeout: got timeout want done"); end
    checks++; if (log_dest.size() != 12) begin errors++; $display("FAIL cont_count: got %0d want 12", log_dest.size()); end
    for (int k = 0; k < 12 && k < log_dest.size(); k++) begin
      logic [AW-1:0] ed;
      logic [DW-1:0] ev;
      ed = (k % 2 == 0) ? 4'd1 : 4'd2;
      ev = ((k % 2 == 0) ? 32'h100 : 32'h200) + DW'(k / 2);
      checks++; if ({log_dest[k], log_data[k]} !== {ed, ev}) begin errors++; $display("FAIL cont_entry%0d: got %h/%h want %h/%h", k, log_dest[k], log_data[k], ed, ev); end
    end
    if (log_cyc.size() == 12) begin
      checks++; if (log_cyc[11] - log_cyc[0] != 11) begin errors++; $display("FAIL cont_gapless: got span %0d want 11", log_cyc[11] - log_cyc[0]); end
    end
  endtask

  task automatic test_back_to_back();
    bit bl, to;
    int ka = 0;
    int kb = 0;
    clear_log();
    run_stream(6, 4, 4'd1, 4'd2, 32'h300, 32'h400, bl, to);
    checks++; if (to) begin errors++; $display("FAIL bp_stream_timeout: got timeout want done"); end
    checks++; if (bl !== 1'b1) begin errors++; $display("FAIL bp_b_ready_low: got %b want 1", bl); end
    drain(to);
    checks++; if (to) begin errors++; $display("FAIL bp_drain_timeout: got timeout want done"); end
    for (int k = 0; k < log_dest.size(); k++) begin
      if (log_dest[k] == 4'd1) begin
        checks++; if (log_data[k] !== 32'h300 + DW'(ka)) begin errors++; $display("FAIL bp_a%0d: got %h want %h", ka, log_data[k], 32'h300 + DW'(ka)); end
        ka++;
      end else begin
        checks++; if ({log_dest[k], log_data[k]} !== {4'd2, 32'h400 + DW'(kb)}) begin errors++; $display("FAIL bp_b%0d: got %h/%h want 2/%h", kb, log_dest[k], log_data[k], 32'h400 + DW'(kb)); end
        kb++;
      end
    end
    checks++; if (ka != 6) begin errors++; $display("FAIL bp_a_count: got %0d want 6", ka); end
    checks++; if (kb != 4) begin errors++; $display("FAIL bp_b_count: got %0d want 4", kb); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dest15();
    test_collision();
    test_contention();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
